// File: rtl/pre_mant_aligner_if.sv
// Operand/result bus for the single-precision adder front end.
// Handshake: a word moves across a channel on any rising clk edge where
// valid and ready are both high; the source holds valid and its data steady
// until that edge, and ready may depend on the sink's state and downstream
// ready but never on the source's valid.
interface pre_mant_aligner_if #(
  parameter int MANT_W = 50
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       op_a;
  logic [31:0]       op_b;
  logic              out_valid;
  logic              out_ready;
  logic [MANT_W-1:0] mant_a;
  logic [MANT_W-1:0] mant_b;
  logic [7:0]        exp_max;
  logic              special;

  // Producer of operand pairs and consumer of aligned results.
  modport master (
    output in_valid, op_a, op_b, out_ready,
    input  in_ready, out_valid, mant_a, mant_b, exp_max, special
  );

  // The aligner itself.
  modport slave (
    input  in_valid, op_a, op_b, out_ready,
    output in_ready, out_valid, mant_a, mant_b, exp_max, special
  );
endinterface

// File: rtl/pre_mant_aligner.sv
// Front end of the binary32 adder: unpacks both operands, picks the larger
// effective exponent and right-aligns the smaller significand, producing two
// signed fixed-point mantissas. Two register stages with full backpressure.
module pre_mant_aligner #(
  parameter int MANT_W  = 50,
  parameter int SIG_LSB = 24
) (
  input  logic               clk,
  input  logic               rst,
  pre_mant_aligner_if.slave  bus
);
  localparam int SIG_W = 24;

  // Stage 1 combinational unpack/compare
  logic [7:0]       w_exp_a, w_exp_b;
  logic [7:0]       w_eff_a, w_eff_b;
  logic [7:0]       w_exp_max, w_diff;
  logic [SIG_W-1:0] w_sig_a, w_sig_b;
  logic             w_a_small, w_b_small, w_special;
  logic             w_s1_adv;

  // Stage 1 registers
  logic             r_s1_valid;
  logic [SIG_W-1:0] r_s1_sig_a, r_s1_sig_b;
  logic             r_s1_sign_a, r_s1_sign_b;
  logic [7:0]       r_s1_exp_max, r_s1_diff;
  logic             r_s1_a_small, r_s1_b_small;
  logic             r_s1_special;

  // Stage 2 combinational align/sign
  logic [MANT_W-1:0] w_mag_a, w_mag_b;
  logic [MANT_W-1:0] w_mant_a, w_mant_b;

  // Stage 2 (output) registers
  logic              r_s2_valid;
  logic [MANT_W-1:0] r_mant_a, r_mant_b;
  logic [7:0]        r_exp_max;
  logic              r_special;

  // Stage 1 advances whenever the output slot is empty or being drained;
  // in_ready depends only on state and out_ready, never on in_valid.
  assign w_s1_adv     = !r_s2_valid || bus.out_ready;
  assign bus.in_ready = !r_s1_valid || w_s1_adv;

  assign w_exp_a   = bus.op_a[30:23];
  assign w_exp_b   = bus.op_b[30:23];
  // Denormals and zero share the exponent of the smallest normal.
  assign w_eff_a   = (w_exp_a == 8'd0) ? 8'd1 : w_exp_a;
  assign w_eff_b   = (w_exp_b == 8'd0) ? 8'd1 : w_exp_b;
  assign w_sig_a   = {(w_exp_a != 8'd0), bus.op_a[22:0]};
  assign w_sig_b   = {(w_exp_b != 8'd0), bus.op_b[22:0]};
  assign w_a_small = (w_eff_a < w_eff_b);
  assign w_b_small = (w_eff_b < w_eff_a);
  assign w_exp_max = w_a_small ? w_eff_b : w_eff_a;
  assign w_diff    = w_a_small ? (w_eff_b - w_eff_a) : (w_eff_a - w_eff_b);
  assign w_special = (w_exp_a == 8'hFF) || (w_exp_b == 8'hFF);

  // Place significands at SIG_LSB, shift only the smaller one (no sticky),
  // then apply the sign as two's complement.
  always_comb begin
    w_mag_a = {{(MANT_W-SIG_W){1'b0}}, r_s1_sig_a} << SIG_LSB;
    w_mag_b = {{(MANT_W-SIG_W){1'b0}}, r_s1_sig_b} << SIG_LSB;
    if (r_s1_a_small) w_mag_a = w_mag_a >> r_s1_diff;
    if (r_s1_b_small) w_mag_b = w_mag_b >> r_s1_diff;
    w_mant_a = r_s1_sign_a ? (~w_mag_a + 1'b1) : w_mag_a;
    w_mant_b = r_s1_sign_b ? (~w_mag_b + 1'b1) : w_mag_b;
  end

  // Stage 1: capture unpacked operands on an input transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid   <= 1'b0;
      r_s1_sig_a   <= '0;
      r_s1_sig_b   <= '0;
      r_s1_sign_a  <= 1'b0;
      r_s1_sign_b  <= 1'b0;
      r_s1_exp_max <= '0;
      r_s1_diff    <= '0;
      r_s1_a_small <= 1'b0;
      r_s1_b_small <= 1'b0;
      r_s1_special <= 1'b0;
    end else if (bus.in_ready) begin
      r_s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_s1_sig_a   <= w_sig_a;
        r_s1_sig_b   <= w_sig_b;
        r_s1_sign_a  <= bus.op_a[31];
        r_s1_sign_b  <= bus.op_b[31];
        r_s1_exp_max <= w_exp_max;
        r_s1_diff    <= w_diff;
        r_s1_a_small <= w_a_small;
        r_s1_b_small <= w_b_small;
        r_s1_special <= w_special;
      end
    end
  end

  // Stage 2: register aligned results; data holds while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_mant_a   <= '0;
      r_mant_b   <= '0;
      r_exp_max  <= '0;
      r_special  <= 1'b0;
    end else if (w_s1_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_mant_a  <= w_mant_a;
        r_mant_b  <= w_mant_b;
        r_exp_max <= r_s1_exp_max;
        r_special <= r_s1_special;
      end
    end
  end

  assign bus.out_valid = r_s2_valid;
  assign bus.mant_a    = r_mant_a;
  assign bus.mant_b    = r_mant_b;
  assign bus.exp_max   = r_exp_max;
  assign bus.special   = r_special;
endmodule

// File: tb/tb_pre_mant_aligner.sv
// Bench for pre_mant_aligner: directed cases, backpressure, reset mid-flight
// and a randomized stream scored against an arithmetic reference model.
module tb_pre_mant_aligner;
  localparam int RW = 109; // {special, exp_max, mant_a, mant_b}

  logic clk = 1'b0;
  logic rst = 1'b1;

  pre_mant_aligner_if bus ();

  pre_mant_aligner dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock/reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [RW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: value of the significand scaled by 2^24, divided by
  // 2^(exp_max - eff_exp) with truncation, negated for sign, modulo 2^50.
  function automatic logic [49:0] ref_mant(input logic [31:0] op, input int emax);
    int     e;
    longint sig;
    longint m;
    logic [63:0] r;
    e   = (op[30:23] == 8'd0) ? 1 : int'(op[30:23]);
    sig = longint'(op[22:0]) + ((op[30:23] != 8'd0) ? 64'd8388608 : 64'd0);
    m   = sig * 64'd16777216;
    if (emax - e >= 48) m = 0;
    else m = m / (longint'(1) << (emax - e));
    if (op[31]) m = -m;
    r = 64'(m);
    return r[49:0];
  endfunction

  function automatic logic [RW-1:0] ref_model(input logic [31:0] a, input logic [31:0] b);
    int ea, eb, emax;
    logic sp;
    logic [7:0] em;
    ea   = (a[30:23] == 8'd0) ? 1 : int'(a[30:23]);
    eb   = (b[30:23] == 8'd0) ? 1 : int'(b[30:23]);
    emax = (ea > eb) ? ea : eb;
    sp   = (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF);
    em   = 8'(emax);
    return {sp, em, ref_mant(a, emax), ref_mant(b, emax)};
  endfunction

  function automatic logic [RW-1:0] dut_word();
    return {bus.special, bus.exp_max, bus.mant_a, bus.mant_b};
  endfunction

  function automatic logic [31:0] rand_op(input int near_exp);
    int e;
    int pick;
    pick = int'($urandom_range(0, 99));
    if (near_exp >= 0 && pick < 50) begin
      e = near_exp + int'($urandom_range(0, 60)) - 30;
      if (e < 0) e = 0;
      if (e > 255) e = 255;
    end else if (pick < 65) e = 0;
    else if (pick < 70) e = 255;
    else e = int'($urandom_range(1, 254));
    return {1'($urandom_range(0, 1)), 8'(e), 23'($urandom)};
  endfunction

  // ---------------- driver/monitor per cycle ----------------
  // Called just after a negedge once inputs are set; settles, then books
  // the transfers that the next rising edge will perform.
  task automatic cycle(output bit in_fire, output bit out_fire);
    logic [RW-1:0] e;
    #1;
    in_fire  = bus.in_valid && bus.in_ready;
    out_fire = bus.out_valid && bus.out_ready;
    if (out_fire) begin
      if (exp_q.size() == 0) check_val("unexpected_out", 64'd1, 64'd0);
      else begin
        e = exp_q.pop_front();
        check_val("sb_special", 64'(bus.special), 64'(e[108]));
        check_val("sb_exp_max", 64'(bus.exp_max), 64'(e[107:100]));
        check_val("sb_mant_a",  64'(bus.mant_a),  64'(e[99:50]));
        check_val("sb_mant_b",  64'(bus.mant_b),  64'(e[49:0]));
      end
    end
    if (in_fire) exp_q.push_back(ref_model(bus.op_a, bus.op_b));
  endtask

  task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [49:0] ema, input logic [49:0] emb,
                          input logic [7:0] ee, input logic esp);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op_a = a; bus.op_b = b; bus.out_ready = 1'b1;
    #1 check_val({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1 check_val({tag, "_lat1_valid"}, 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    #1;
    check_val({tag, "_out_valid"}, 64'(bus.out_valid), 64'd1);
    check_val({tag, "_mant_a"},    64'(bus.mant_a),    64'(ema));
    check_val({tag, "_mant_b"},    64'(bus.mant_b),    64'(emb));
    check_val({tag, "_exp_max"},   64'(bus.exp_max),   64'(ee));
    check_val({tag, "_special"},   64'(bus.special),   64'(esp));
  endtask

  task automatic run_random(input int n, input int rdy_pct);
    int sent = 0;
    int budget = 0;
    bit pend = 1'b0;
    bit held_v = 1'b0;
    bit inf, outf;
    logic [RW-1:0] held;
    logic [31:0] a;
    while ((sent < n || exp_q.size() > 0 || pend) && budget < 3000) begin
      @(negedge clk);
      if (held_v) check_val("hold_stable", 64'(dut_word() != held), 64'd0);
      if (!pend && sent < n && $urandom_range(0, 99) < 80) begin
        pend = 1'b1;
        a = rand_op(-1);
        bus.op_a = a;
        bus.op_b = rand_op(int'(a[30:23]));
      end
      bus.in_valid  = pend;
      bus.out_ready = ($urandom_range(0, 99) < rdy_pct);
      cycle(inf, outf);
      if (inf) begin pend = 1'b0; sent++; end
      held_v = bus.out_valid && !bus.out_ready;
      held   = dut_word();
      budget++;
    end
    if (budget >= 3000) check_val("stream_timeout", 64'd1, 64'd0);
    @(negedge clk);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] bp_a[4];
    logic [31:0] bp_b[4];
    logic [RW-1:0] held;
    int acc, nout, first_c, last_c;
    bit inf, outf;

    bus.in_valid = 1'b0; bus.op_a = '0; bus.op_b = '0; bus.out_ready = 1'b1;

    // Reset state
    #2;
    check_val("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_val("rst_word",      64'(dut_word() != '0), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1 check_val("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Directed cases
    directed("one_one",   32'h3F800000, 32'h3F800000, 50'h0800000000000, 50'h0800000000000, 8'd127, 1'b0);
    directed("one_mhalf", 32'h3F800000, 32'hBF000000, 50'h0800000000000, 50'h3C00000000000, 8'd127, 1'b0);
    directed("gap60",     32'h3F800000, 32'h21800000, 50'h0800000000000, 50'h0,             8'd127, 1'b0);
    directed("gap48",     32'h3F800000, 32'h27800000, 50'h0800000000000, 50'h0,             8'd127, 1'b0);
    directed("gap47",     32'h3F800000, 32'h28000000, 50'h0800000000000, 50'h1,             8'd127, 1'b0);
    directed("denorm",    32'h00000001, 32'h00000000, 50'h0000001000000, 50'h0,             8'd1,   1'b0);
    directed("inf",       32'h7F800000, 32'h3F800000, 50'h0800000000000, 50'h0,             8'd255, 1'b1);
    directed("neg_zero",  32'h80000000, 32'h00800000, 50'h0,             50'h0800000000000, 8'd1,   1'b0);

    // Backpressure: 4 pairs offered with out_ready low for 5 cycles
    for (int i = 0; i < 4; i++) begin
      bp_a[i] = rand_op(-1);
      bp_b[i] = rand_op(int'(bp_a[i][30:23]));
    end
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c > 2) check_val("bp_hold", 64'(dut_word() != held), 64'd0);
      bus.out_ready = 1'b0;
      bus.in_valid  = (acc < 4);
      bus.op_a = bp_a[acc % 4]; bus.op_b = bp_b[acc % 4];
      cycle(inf, outf);
      if (inf) acc++;
      if (c == 2) held = dut_word();
    end
    check_val("bp_accepted",  64'(acc),           64'd2);
    check_val("bp_in_ready",  64'(bus.in_ready),  64'd0);
    check_val("bp_out_valid", 64'(bus.out_valid), 64'd1);
    nout = 0; first_c = -1; last_c = -1;
    for (int c = 0; c < 20 && nout < 4; c++) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      bus.in_valid  = (acc < 4);
      bus.op_a = bp_a[acc % 4]; bus.op_b = bp_b[acc % 4];
      cycle(inf, outf);
      if (inf) acc++;
      if (outf) begin
        if (first_c < 0) first_c = c;
        last_c = c;
        nout++;
      end
    end
    check_val("bp_outputs",    64'(nout),            64'd4);
    check_val("bp_throughput", 64'(last_c - first_c), 64'd3);
    check_val("bp_queue_empty", 64'(exp_q.size()),   64'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;

    // Reset mid-flight with both stages occupied
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.op_a = 32'hC0400000; bus.op_b = 32'h3F800000;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1 check_val("mid_full_in_ready", 64'(bus.in_ready), 64'd0);
    rst = 1'b1;
    #1;
    check_val("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_val("mid_rst_word",      64'(dut_word() != '0), 64'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    #1 check_val("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    check_val("mid_rst_no_stale", 64'(bus.out_valid), 64'd0);
    directed("after_rst", 32'h40000000, 32'hBF800000, 50'h0800000000000, 50'h3C00000000000, 8'd128, 1'b0);

    // Randomized streams, full throughput then random backpressure
    run_random(60, 100);
    run_random(120, 50);
    run_random(60, 15);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule

// File: doc/pre_mant_aligner.md
Name: pre_mant_aligner

Overview:
- Front end of the single-precision adder datapath; runs in the opposite direction to the post-normalisation mantissa stage.
- Unpacks two IEEE-754 binary32 operands and selects the larger exponent (exp_max).
- Right-aligns the smaller operand's significand and emits two signed 50-bit mantissas plus exp_max. The downstream adder/normaliser consumes these.
- 2-stage valid/ready pipeline with full backpressure.

Parameters:
- MANT_W, 50, width of aligned signed mantissa outputs.
- SIG_LSB, 24, bit position of significand LSB inside the aligned field; significand occupies [SIG_LSB+23:SIG_LSB].

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept a pair this cycle.
- op_a  in  32  binary32 operand A.
- op_b  in  32  binary32 operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- mant_a  out  50  aligned two's-complement mantissa of A.
- mant_b  out  50  aligned two's-complement mantissa of B.
- exp_max  out  8  larger effective exponent.
- special  out  1  either operand has exp==255 (Inf/NaN); mantissas still computed from raw fields.

Behaviour:
- Reset (async, immediate): stage valids cleared; out_valid=0, mant_a=0, mant_b=0, exp_max=0, special=0. in_ready is 1 in the cycle after reset deasserts.
- Handshake:
  - Transfer on in_valid&in_ready and on out_valid&out_ready.
  - in_ready = !s1_valid | s1_advance; s1_advance = !s2_valid | out_ready. Combinational from out_ready; no combinational path from in_valid to in_ready.
  - Output data held stable while out_valid&!out_ready.
- Latency: 2 cycles from input transfer to out_valid. Throughput is 1 pair/cycle when out_ready=1.
- Stage 1 (unpack/compare):
  - Per operand: e=exp field, f=frac field.
  - Normal (e!=0): sig={1,f}, eff_exp=e.
  - Denormal/zero (e==0): sig={0,f}, eff_exp=1.
  - exp_max=max(eff_exp_a, eff_exp_b). diff=|eff_exp_a-eff_exp_b| (8-bit unsigned). Record which operand is smaller; on a tie neither operand is shifted.
  - Register sig_a, sig_b, signs, exp_max, diff, which-smaller and special.
- Stage 2 (align/sign):
  - mag = sig << SIG_LSB, zero-extended to 50 bits, so bits 49:48 are 0.
  - Smaller operand: mag >> diff. Any diff >= 48 gives 0. Bits shifted below bit 0 are discarded; there is no sticky bit.
  - Output = sign ? (~mag+1) : mag, 50-bit. A sign=1 with mag=0 gives 0.
- Simultaneous events: an input transfer and an output transfer in the same cycle are both accepted; the pipeline shifts with no bubble.
- Full stall: with s1 and s2 both valid and out_ready=0, in_ready=0 and all registers hold.
- Reset mid-operation: in-flight pairs are discarded; no partial result is emitted.

Test Plan:
- 1.0+1.0: op_a=op_b=32'h3F800000 -> after 2 cycles out_valid=1, exp_max=127, mant_a=mant_b=50'h0800000000000, special=0.
- 1.0 with -0.5: op_a=32'h3F800000, op_b=32'hBF000000 -> exp_max=127, mant_a=50'h0800000000000, mant_b=-(50'h0400000000000)=50'h3C00000000000.
- Large exponent gap: op_a=32'h3F800000, op_b=32'h21800000 (e=67, diff=60) -> mant_b=0, exp_max=127. Also op_b with e=79 (diff=48) -> mant_b=0; with e=80 (diff=47) -> mant_b=50'h1.
- Denormals/zero: op_a=32'h00000001, op_b=32'h00000000 -> exp_max=1, mant_a=50'h1000000, mant_b=0. op_a=32'h7F800000 -> special=1.
- Backpressure: stream 4 pairs with out_ready=0 for 5 cycles.
  - in_ready drops after 2 accepted pairs and results hold stable.
  - After out_ready=1, all 4 results arrive in order with no loss or duplication.
  - Back-to-back throughput is 1/cycle.
- Reset mid-flight: assert rst with s1 and s2 valid -> out_valid=0 and outputs 0 in the same cycle. After release, new input gives a correct result 2 cycles later with no stale data.
